// File: rtl/soft_bus_pkg.sv
// rtl/soft_bus_pkg.sv - shared command encodings, FSM state codes and default widths for the bus arbiter
package soft_bus_pkg;

  localparam int NUM_MASTERS_DEF = 2;
  localparam int AW_DEF          = 32;
  localparam int DW_DEF          = 32;
  localparam int CW_DEF          = 4;
  localparam int TIMEOUT_DEF     = 64;

  localparam int CMD_IDLE  = 0;
  localparam int CMD_READ  = 1;
  localparam int CMD_WRITE = 2;

  typedef logic [1:0] arbState_t;
  localparam arbState_t ST_IDLE = 2'd0;
  localparam arbState_t ST_BUSY = 2'd1;
  localparam arbState_t ST_RESP = 2'd2;

  function automatic int ptrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/soft_bus_arbiter_rr_picker.sv
// rtl/soft_bus_arbiter_rr_picker.sv - combinational round-robin picker (req vector, last grant -> next grant, valid)
module rr_picker
  import soft_bus_pkg::*;
#(
  parameter int N  = NUM_MASTERS_DEF,
  parameter int PW = ptrWidth(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          valid
);

  int idx;

  // Scan from the farthest slot to the nearest so the last hit is the one closest after ptr.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int off = N; off >= 1; off--) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (req[PW'(idx)]) begin
        grant = PW'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/soft_bus_arbiter.sv
// rtl/soft_bus_arbiter.sv - N-master to 1-slave round-robin command bus arbiter, one outstanding transaction
// Optional slave response timeout is enabled by defining SOFT_ARB_TIMEOUT_EN.
module soft_bus_arbiter
  import soft_bus_pkg::*;
#(
  parameter int NUM_MASTERS = NUM_MASTERS_DEF,
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int CW          = CW_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_MASTERS*CW-1:0] mCommand,
  input  logic [NUM_MASTERS*AW-1:0] mAddress,
  input  logic [NUM_MASTERS*DW-1:0] mData,
  output logic [NUM_MASTERS-1:0]    mReady,
  output logic [NUM_MASTERS-1:0]    mSignal,
  output logic [DW-1:0]             mHData,
  output logic [CW-1:0]             sCommand,
  output logic [AW-1:0]             sAddress,
  output logic [DW-1:0]             sData,
  input  logic                      sReady,
  input  logic                      sSignal,
  input  logic [DW-1:0]             sHData
);

  localparam int PW = ptrWidth(NUM_MASTERS);

  if (NUM_MASTERS < 1 || TIMEOUT < 1) begin : gBadParams
    $error("soft_bus_arbiter: NUM_MASTERS and TIMEOUT must be >= 1");
  end

  arbState_t              state;
  logic [PW-1:0]          ptr;
  logic [PW-1:0]          gIdx;
  logic [PW-1:0]          pickIdx;
  logic                   pickValid;
  logic [NUM_MASTERS-1:0] reqVec;
  logic [NUM_MASTERS-1:0] gMask;
  logic [CW-1:0]          selCommand;
  logic [AW-1:0]          selAddress;
  logic [DW-1:0]          selData;
  logic [AW-1:0]          lAddress;
  logic [DW-1:0]          lData;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : gReq
    assign reqVec[i] = |mCommand[i*CW +: CW];
  end

  rr_picker #(
    .N  (NUM_MASTERS),
    .PW (PW)
  ) uPicker (
    .req   (reqVec),
    .ptr   (ptr),
    .grant (pickIdx),
    .valid (pickValid)
  );

  always_comb begin
    selCommand = mCommand[int'(pickIdx)*CW +: CW];
    selAddress = mAddress[int'(pickIdx)*AW +: AW];
    selData    = mData[int'(pickIdx)*DW +: DW];
    gMask      = NUM_MASTERS'(1) << gIdx;
  end

  assign sAddress = lAddress;
  assign sData    = lData;

`ifdef SOFT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] toCnt;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      ptr      <= PW'(NUM_MASTERS - 1);
      gIdx     <= '0;
      sCommand <= '0;
      lAddress <= '0;
      lData    <= '0;
      mReady   <= '0;
      mSignal  <= '0;
      mHData   <= '0;
`ifdef SOFT_ARB_TIMEOUT_EN
      toCnt    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (pickValid) begin
            gIdx     <= pickIdx;
            ptr      <= pickIdx;
            sCommand <= selCommand;
            lAddress <= selAddress;
            lData    <= selData;
            state    <= ST_BUSY;
`ifdef SOFT_ARB_TIMEOUT_EN
            toCnt    <= '0;
`endif
          end
        end
        // Master inputs are deliberately not looked at here; the slave sees the latched request.
        ST_BUSY: begin
          if (sReady) begin
            sCommand <= '0;
            mReady   <= gMask;
            mSignal  <= sSignal ? gMask : '0;
            mHData   <= sHData;
            state    <= ST_RESP;
          end
`ifdef SOFT_ARB_TIMEOUT_EN
          else if (toCnt == TW'(TIMEOUT - 1)) begin
            sCommand <= '0;
            mReady   <= gMask;
            mSignal  <= gMask;
            mHData   <= '0;
            state    <= ST_RESP;
          end else begin
            toCnt <= toCnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          mReady  <= '0;
          mSignal <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soft_bus_arbiter.sv
// tb/tb_soft_bus_arbiter.sv - scoreboard bench for soft_bus_arbiter with four masters and a modelled slave
module tb_soft_bus_arbiter;
  import soft_bus_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int TO = 8;
  localparam logic [31:0] MASK = 32'hA5A5_0000;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [N*CW-1:0] mCommand = '0;
  logic [N*AW-1:0] mAddress = '0;
  logic [N*DW-1:0] mData = '0;
  logic [N-1:0]    mReady;
  logic [N-1:0]    mSignal;
  logic [DW-1:0]   mHData;
  logic [CW-1:0]   sCommand;
  logic [AW-1:0]   sAddress;
  logic [DW-1:0]   sData;
  logic            sReady = 1'b0;
  logic            sSignal = 1'b0;
  logic [DW-1:0]   sHData = '0;

  soft_bus_arbiter #(
    .NUM_MASTERS (N),
    .AW          (AW),
    .DW          (DW),
    .CW          (CW),
    .TIMEOUT     (TO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .mCommand (mCommand),
    .mAddress (mAddress),
    .mData    (mData),
    .mReady   (mReady),
    .mSignal  (mSignal),
    .mHData   (mHData),
    .sCommand (sCommand),
    .sAddress (sAddress),
    .sData    (sData),
    .sReady   (sReady),
    .sSignal  (sSignal),
    .sHData   (sHData)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0]  rdy;
    logic [N-1:0]  sig;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sbQ[$];
  int   assertCount = 0;
  int   failCount = 0;
  int   remaining[N];
  int   seqNum[N];
  logic [CW-1:0] masterCmd[N];
  bit   slaveAuto = 0;
  bit   slaveFault = 0;
  int   slaveWait = 0;
  int   waitCnt = 0;
  bit   spacingOn = 0;
  int   lastRdy = -1;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] baseAddr(input int i);
    return 32'h1000 * (i + 1);
  endfunction

  task automatic setCmd(input int i, input logic [CW-1:0] cmd, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data);
    mCommand[i*CW +: CW] = cmd;
    mAddress[i*AW +: AW] = addr;
    mData[i*DW +: DW]    = data;
  endtask

  task automatic startMaster(input int i, input int count, input logic [CW-1:0] cmd);
    remaining[i] = count;
    seqNum[i]    = 0;
    masterCmd[i] = cmd;
    setCmd(i, cmd, baseAddr(i), 32'h0D00 + i);
  endtask

  // One negedge: scoreboard monitor, then master and slave models react.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    if (mReady != '0) begin
      if (sbQ.size() == 0) begin
        checkVal("unexpected_mready", mReady, 0);
      end else begin
        e = sbQ.pop_front();
        checkVal("sb_mready", mReady, e.rdy);
        checkVal("sb_msignal", mSignal, e.sig);
        checkVal("sb_mhdata", mHData, e.data);
      end
      if (spacingOn) begin
        if (lastRdy >= 0) checkVal("rr_spacing", cyc - lastRdy, 3);
        lastRdy = cyc;
      end
    end else if (mSignal != '0) begin
      checkVal("msignal_without_mready", mSignal, 0);
    end
    for (int i = 0; i < N; i++) begin
      if (mReady[i] && remaining[i] > 0) begin
        remaining[i]--;
        seqNum[i]++;
        if (remaining[i] > 0) setCmd(i, masterCmd[i], baseAddr(i) + seqNum[i] * 4, 32'h0D00 + i);
        else setCmd(i, '0, '0, '0);
      end
    end
    if (slaveAuto) begin
      if (sReady) begin
        sReady  = 1'b0;
        sSignal = 1'b0;
      end else if (sCommand != '0) begin
        if (waitCnt >= slaveWait) begin
          sReady  = 1'b1;
          sSignal = slaveFault;
          sHData  = sAddress ^ MASK;
          waitCnt = 0;
        end else begin
          waitCnt++;
        end
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic waitDrain(input string tag, input int budget);
    int k;
    k = 0;
    while (sbQ.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    checkVal(tag, sbQ.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      remaining[i] = 0;
      seqNum[i]    = 0;
      masterCmd[i] = '0;
    end

    // Reset state
    ticks(2);
    checkVal("rst_scommand", sCommand, 0);
    checkVal("rst_mready", mReady, 0);
    checkVal("rst_msignal", mSignal, 0);
    checkVal("rst_mhdata", mHData, 0);
    checkVal("rst_saddress", sAddress, 0);
    reset = 1'b1;
    tick();

    // Single M0 read, slave answers in cycle 3
    setCmd(0, CW'(CMD_READ), 32'h100, 32'h0);
    tick();
    checkVal("t2_scommand_c1", sCommand, CMD_READ);
    checkVal("t2_saddress_c1", sAddress, 32'h100);
    tick();
    checkVal("t2_no_mready_c2", mReady, 0);
    tick();
    sReady  = 1'b1;
    sSignal = 1'b0;
    sHData  = 32'hDEADBEEF;
    sbQ.push_back('{rdy: 4'b0001, sig: 4'b0000, data: 32'hDEADBEEF});
    tick();
    checkVal("t2_mready_c4", mReady, 4'b0001);
    checkVal("t2_scommand_c4", sCommand, 0);
    sReady = 1'b0;
    setCmd(0, '0, '0, '0);
    tick();
    checkVal("t2_mready_one_cycle", mReady, 0);

    // Slave fault on M2 write, two wait states
    slaveAuto = 1; slaveWait = 2; slaveFault = 1; waitCnt = 0;
    sbQ.push_back('{rdy: 4'b0100, sig: 4'b0100, data: baseAddr(2) ^ MASK});
    startMaster(2, 1, CW'(CMD_WRITE));
    waitDrain("t4_drain", 40);
    slaveAuto = 0; slaveFault = 0;
    ticks(2);

    // Spurious sReady in IDLE, then M1 changes its inputs while BUSY
    sReady = 1'b1;
    tick();
    sReady = 1'b0;
    ticks(2);
    checkVal("t5_spurious_no_mready", mReady, 0);
    setCmd(1, CW'(CMD_WRITE), 32'h200, 32'hCAFE);
    tick();
    setCmd(1, CW'(CMD_READ), 32'h999, 32'hBAD);
    tick();
    checkVal("t5_saddress_held", sAddress, 32'h200);
    checkVal("t5_sdata_held", sData, 32'hCAFE);
    checkVal("t5_scommand_held", sCommand, CMD_WRITE);
    ticks(2);
    checkVal("t5_saddress_held_late", sAddress, 32'h200);
    sReady = 1'b1;
    sHData = 32'h55AA;
    sbQ.push_back('{rdy: 4'b0010, sig: 4'b0000, data: 32'h55AA});
    tick();
    checkVal("t5_mready", mReady, 4'b0010);
    sReady = 1'b0;
    setCmd(1, '0, '0, '0);
    ticks(2);

    // Reset in the middle of a transaction; afterwards M0 wins over M1
    setCmd(0, CW'(CMD_READ), 32'h40, 32'h0);
    ticks(2);
    reset = 1'b0;
    #1;
    checkVal("t1_scommand_async", sCommand, 0);
    checkVal("t1_mready_async", mReady, 0);
    setCmd(0, '0, '0, '0);
    ticks(2);
    reset = 1'b1;
    tick();
    slaveAuto = 1; slaveWait = 0; waitCnt = 0;
    sbQ.push_back('{rdy: 4'b0001, sig: 4'b0000, data: baseAddr(0) ^ MASK});
    sbQ.push_back('{rdy: 4'b0010, sig: 4'b0000, data: baseAddr(1) ^ MASK});
    startMaster(0, 1, CW'(CMD_READ));
    startMaster(1, 1, CW'(CMD_READ));
    waitDrain("t1_drain", 40);
    ticks(2);

    // Four continuous requesters, zero-wait slave
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        sbQ.push_back('{rdy: N'(1) << i, sig: '0, data: (baseAddr(i) + r * 4) ^ MASK});
    spacingOn = 1; lastRdy = -1;
    for (int i = 0; i < N; i++) startMaster(i, 2, (i % 2 == 0) ? CW'(CMD_READ) : CW'(CMD_WRITE));
    waitDrain("t3_drain", 200);
    spacingOn = 0;
    slaveAuto = 0;
    ticks(3);

    // Silent slave
    setCmd(2, CW'(CMD_READ), 32'h600, 32'h0);
`ifdef SOFT_ARB_TIMEOUT_EN
    ticks(TO);
    checkVal("t6_busy_last_cycle", sCommand, CMD_READ);
    sbQ.push_back('{rdy: 4'b0100, sig: 4'b0100, data: 32'h0});
    tick();
    checkVal("t6_scommand_dropped", sCommand, 0);
    checkVal("t6_mready", mReady, 4'b0100);
    checkVal("t6_msignal", mSignal, 4'b0100);
    checkVal("t6_mhdata", mHData, 0);
    setCmd(2, '0, '0, '0);
    tick();
    sReady = 1'b1;
    tick();
    sReady = 1'b0;
    ticks(3);
    checkVal("t6_late_sready_ignored", mReady, 0);
`else
    ticks(1000);
    checkVal("t6_still_busy", sCommand, CMD_READ);
    checkVal("t6_still_addr", sAddress, 32'h600);
    reset = 1'b0;
    setCmd(2, '0, '0, '0);
    tick();
    reset = 1'b1;
    ticks(2);
`endif

    ticks(3);
    checkVal("sb_empty_at_end", sbQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
